// File: rtl/segment_scan_driver.sv
// Multiplexed 7-segment scan driver: FIELDS binary fields shown as two decimal digits each, with
// blank gap, PWM brightness, leading-zero blanking and per-frame input snapshot; outputs lag counters by one cycle.
module segment_scan_driver #(
  parameter int FIELDS    = 2,
  parameter int FIELD_W   = 6,
  parameter int SCAN_DIV  = 1024,
  parameter int BLANK_CYC = 8
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [FIELDS*FIELD_W-1:0] data_show,
  input  logic [2*FIELDS-1:0]       digit_en,
  input  logic [2*FIELDS-1:0]       dp_mask,
  input  logic [3:0]                brightness,
  input  logic                      lz_blank,
  output logic [2*FIELDS-1:0]       bytee,
  output logic [6:0]                segment,
  output logic                      dp,
  output logic                      frame_start
);

  localparam int DIGITS  = 2 * FIELDS;
  localparam int SW      = $clog2(SCAN_DIV);
  localparam int DW      = $clog2(DIGITS);
  localparam int ON_UNIT = (SCAN_DIV - BLANK_CYC) / 16;

  logic [SW-1:0]             slot_cnt_q, slot_cnt_d;
  logic [DW-1:0]             digit_idx_q, digit_idx_d;
  logic [FIELDS*FIELD_W-1:0] data_q;
  logic [DIGITS-1:0]         en_q, dpm_q;
  logic [3:0]                bright_q;
  logic                      lz_q;
  logic [DIGITS-1:0]         bytee_q, bytee_d;
  logic [6:0]                seg_q, seg_d;
  logic                      dp_q, dp_d;
  logic                      fs_q;

  logic                      frame_begin;
  logic [FIELDS*FIELD_W-1:0] data_eff;
  logic [DIGITS-1:0]         en_eff, dpm_eff;
  logic [3:0]                bright_eff;
  logic                      lz_eff;
  logic [FIELD_W-1:0]        fval;
  logic [7:0]                val, ones, tens, digit_v;
  logic [6:0]                seg_v;
  logic [31:0]               win, slot;
  logic                      is_tens, in_win, lz_hit, lit;

  function automatic logic [6:0] decode(input logic [7:0] v);
    case (v)
      8'd0: decode = 7'h3f;
      8'd1: decode = 7'h06;
      8'd2: decode = 7'h5b;
      8'd3: decode = 7'h4f;
      8'd4: decode = 7'h66;
      8'd5: decode = 7'h6d;
      8'd6: decode = 7'h7d;
      8'd7: decode = 7'h07;
      8'd8: decode = 7'h7f;
      8'd9: decode = 7'h6f;
      default: decode = 7'h00;
    endcase
  endfunction

  // The frame's first cycle uses live inputs so it already matches what the snapshot will hold.
  assign frame_begin = (slot_cnt_q == '0) && (digit_idx_q == '0);
  assign data_eff    = frame_begin ? data_show  : data_q;
  assign en_eff      = frame_begin ? digit_en   : en_q;
  assign dpm_eff     = frame_begin ? dp_mask    : dpm_q;
  assign bright_eff  = frame_begin ? brightness : bright_q;
  assign lz_eff      = frame_begin ? lz_blank   : lz_q;

  always_comb begin
    slot_cnt_d  = slot_cnt_q + 1'b1;
    digit_idx_d = digit_idx_q;
    if (slot_cnt_q == SW'(SCAN_DIV - 1)) begin
      slot_cnt_d  = '0;
      digit_idx_d = (digit_idx_q == DW'(DIGITS - 1)) ? '0 : digit_idx_q + 1'b1;
    end
  end

  always_comb begin
    fval = '0;
    for (int f = 0; f < FIELDS; f++) begin
      if (int'(digit_idx_q >> 1) == f) fval = data_eff[f*FIELD_W +: FIELD_W];
    end
    val     = 8'(fval);
    ones    = val % 8'd10;
    tens    = val / 8'd10;
    is_tens = digit_idx_q[0];
    digit_v = is_tens ? tens : ones;
    seg_v   = (val >= 8'd100) ? 7'h40 : decode(digit_v);
    win     = (bright_eff == 4'd15) ? 32'(SCAN_DIV - BLANK_CYC) : 32'(bright_eff) * 32'(ON_UNIT);
    slot    = 32'(slot_cnt_q);
    in_win  = (slot >= 32'(BLANK_CYC)) && (slot < 32'(BLANK_CYC) + win);
    lz_hit  = lz_eff && is_tens && (tens == 8'd0);
    lit     = in_win && en_eff[digit_idx_q] && !lz_hit;
    bytee_d = '1;
    seg_d   = '0;
    dp_d    = 1'b0;
    if (lit) begin
      bytee_d[digit_idx_q] = 1'b0;
      seg_d                = seg_v;
      dp_d                 = dpm_eff[digit_idx_q];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      slot_cnt_q  <= '0;
      digit_idx_q <= '0;
      data_q      <= '0;
      en_q        <= '0;
      dpm_q       <= '0;
      bright_q    <= 4'd15;
      lz_q        <= 1'b0;
      bytee_q     <= '1;
      seg_q       <= '0;
      dp_q        <= 1'b0;
      fs_q        <= 1'b0;
    end else begin
      slot_cnt_q  <= slot_cnt_d;
      digit_idx_q <= digit_idx_d;
      if (frame_begin) begin
        data_q   <= data_show;
        en_q     <= digit_en;
        dpm_q    <= dp_mask;
        bright_q <= brightness;
        lz_q     <= lz_blank;
      end
      bytee_q <= bytee_d;
      seg_q   <= seg_d;
      dp_q    <= dp_d;
      fs_q    <= frame_begin;
    end
  end

  assign bytee       = bytee_q;
  assign segment     = seg_q;
  assign dp          = dp_q;
  assign frame_start = fs_q;

endmodule
